cnn_layer_accel_weight_seq_gen: RTL and testbench
=================================================

// Module: cnn_layer_accel_weight_seq_gen
// PURPOSE
// - Programmable weight-address sequencer for the QUAD weight path: holds C_NUM_SEQ runtime-loadable sequences of weight-RAM addresses.
// - On start, streams the selected sequence out under a valid/ready handshake.
// - Replaces the fixed 4x5 reset-loaded table; supports any kernel size up to C_SEQ_DEPTH entries and per-sequence lengths.
// PARAMETERS
// - C_NUM_SEQ    4   number of sequences (>=2, power of 2)
// - C_SEQ_DEPTH  8   max entries per sequence (>=1)
// - C_ADDR_WIDTH 4   width of a weight address entry
// - Derived: SW=clog2(C_NUM_SEQ), IW=clog2(C_SEQ_DEPTH), LW=clog2(C_SEQ_DEPTH+1)
// PORTS
// - clk           in   1   clock
// - rst           in   1   synchronous, active-high reset
// - cfg_wr_en     in   1   write table entry cfg_data at [cfg_seq_id][cfg_idx]
// - cfg_len_wr    in   1   write sequence length cfg_len for cfg_seq_id
// - cfg_seq_id    in   SW  target sequence of a config write
// - cfg_idx       in   IW  target entry index
// - cfg_data      in   C_ADDR_WIDTH  entry value
// - cfg_len       in   LW  sequence length, 0..C_SEQ_DEPTH
// - cfg_err       out  1   one-cycle pulse: config write rejected
// - start         in   1   begin streaming sequence seq_sel (pulse)
// - seq_sel       in   SW  sequence to stream; legacy map = {^gray_code, ~sequence_selector}
// - busy          out  1   high from accepted start until done
// - wht_valid     out  1   wht_data_addr valid
// - wht_ready     in   1   downstream accepts beat
// - wht_data_addr out  C_ADDR_WIDTH  weight RAM address
// - wht_last      out  1   marks final beat of the sequence (final repeat when enabled)
// - done          out  1   one-cycle pulse after last beat accepted
// BEHAVIOUR
// - Reset: all table entries and lengths = 0; state IDLE; busy, wht_valid, wht_last, done, cfg_err = 0; wht_data_addr = 0.
// - FSM IDLE -> RUN on start; RUN -> IDLE when beat with wht_last accepted (wht_valid & wht_ready), done pulses that next cycle.
// - start in IDLE latches seq_sel and its length; start seen while busy is ignored (no error).
// - Length 0: start -> done pulses next cycle, busy high exactly that one cycle, no beats emitted.
// - Latency: start in cycle T -> wht_valid=1 with entry 0 in T+1. Output register: one beat per cycle at full throughput.
// - Handshake: while wht_valid & !wht_ready, wht_data_addr/wht_last hold stable; index advances only on accept.
// - Index counts 0..len-1; wht_last = (idx == len-1) on final pass; no wrap past len.
// - Config writes: accepted any time, except to the sequence currently streaming while busy -> ignored, cfg_err pulses the next cycle.
// - cfg_len > C_SEQ_DEPTH is clamped to C_SEQ_DEPTH; cfg_idx >= C_SEQ_DEPTH write ignored, cfg_err pulses.
// - Simultaneous cfg_wr_en and cfg_len_wr both apply (same rejection rules). Write to the sequence selected by a same-cycle start is rejected.
// - rst mid-stream: returns to IDLE next cycle, wht_valid drops, no done pulse, table contents cleared.
// CONFIGURATION
// - WHT_SEQ_REPEAT_EN defined:
//   - adds input rpt_count [7:0], latched at start.
//   - sequence streamed rpt_count+1 times back-to-back, no bubble between passes.
//   - wht_last only on the final entry of the final pass.
// - Not defined: no rpt_count port; single pass per start.
// TESTING
// - Load seq0 = {1,9,3,4,5}, len 5; start seq_sel=0, ready=1 -> addrs 1,9,3,4,5 on T+1..T+5, last at T+5, done at T+6.
// - Same stream, ready low on cycles 2-4 -> beat 9 held stable; all 5 beats delivered in order; done one cycle after last accept.
// - len 0 on seq2; start -> no wht_valid, done at T+1.
// - cfg_wr_en to seq1 during seq1 stream -> entry unchanged, cfg_err pulses. Write to seq3 in the same window -> accepted.
// - cfg_len=12 with C_SEQ_DEPTH 8 -> 8 beats. Assert rst at beat 3 -> wht_valid=0 and busy=0 next cycle; table reads 0.
// - WHT_SEQ_REPEAT_EN, rpt_count=2, seq {6,7,8} -> 6,7,8,6,7,8,6,7,8; single last on the final 8.

Source files
------------

// File: rtl/cnn_layer_accel_weight_seq_gen_if.sv
// Purpose : config, start/status and weight-address stream signals of the weight sequencer.
// Ports   : cfg_* table/length writes and cfg_err; start/seq_sel/busy/done control;
//           wht_valid/wht_ready/wht_data_addr/wht_last stream; rpt_count only with WHT_SEQ_REPEAT_EN.
// Modports: master = controller/consumer side, slave = sequencer side.
interface cnn_layer_accel_weight_seq_gen_if #(
    parameter int C_NUM_SEQ    = 4,
    parameter int C_SEQ_DEPTH  = 8,
    parameter int C_ADDR_WIDTH = 4
);
    localparam int SW = $clog2(C_NUM_SEQ);
    localparam int IW = (C_SEQ_DEPTH > 1) ? $clog2(C_SEQ_DEPTH) : 1;
    localparam int LW = $clog2(C_SEQ_DEPTH + 1);

    logic                    cfg_wr_en;
    logic                    cfg_len_wr;
    logic [SW-1:0]           cfg_seq_id;
    logic [IW-1:0]           cfg_idx;
    logic [C_ADDR_WIDTH-1:0] cfg_data;
    logic [LW-1:0]           cfg_len;
    logic                    cfg_err;
    logic                    start;
    logic [SW-1:0]           seq_sel;
    logic                    busy;
    logic                    wht_valid;
    logic                    wht_ready;
    logic [C_ADDR_WIDTH-1:0] wht_data_addr;
    logic                    wht_last;
    logic                    done;
`ifdef WHT_SEQ_REPEAT_EN
    logic [7:0]              rpt_count;
`endif

    modport master (
        output cfg_wr_en, cfg_len_wr, cfg_seq_id, cfg_idx, cfg_data, cfg_len,
        output start, seq_sel, wht_ready,
`ifdef WHT_SEQ_REPEAT_EN
        output rpt_count,
`endif
        input  cfg_err, busy, wht_valid, wht_data_addr, wht_last, done
    );

    modport slave (
        input  cfg_wr_en, cfg_len_wr, cfg_seq_id, cfg_idx, cfg_data, cfg_len,
        input  start, seq_sel, wht_ready,
`ifdef WHT_SEQ_REPEAT_EN
        input  rpt_count,
`endif
        output cfg_err, busy, wht_valid, wht_data_addr, wht_last, done
    );
endinterface

// File: rtl/cnn_layer_accel_weight_seq_gen.sv
// Purpose : programmable weight-address sequencer; C_NUM_SEQ runtime-loaded tables streamed on start.
// Latency : start in cycle T -> first beat valid in T+1, then one beat per cycle; done one cycle after last accept.
// Backpressure: output register holds address/last while wht_valid & !wht_ready; index advances only on accept.
// Ports   : clk, rst (sync, active-high); s_if (slave modport) carries config, control and the stream.
// Option  : WHT_SEQ_REPEAT_EN adds rpt_count; the sequence is replayed rpt_count+1 times back-to-back.
module cnn_layer_accel_weight_seq_gen #(
    parameter int C_NUM_SEQ    = 4,
    parameter int C_SEQ_DEPTH  = 8,
    parameter int C_ADDR_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    cnn_layer_accel_weight_seq_gen_if.slave   s_if
);
    localparam int SW = $clog2(C_NUM_SEQ);
    localparam int IW = (C_SEQ_DEPTH > 1) ? $clog2(C_SEQ_DEPTH) : 1;
    localparam int LW = $clog2(C_SEQ_DEPTH + 1);

    // S_FIN is the single done cycle; busy stays high through it.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_busy;
    logic                    w_done;

    logic [C_ADDR_WIDTH-1:0] r_tab [C_NUM_SEQ][C_SEQ_DEPTH];
    logic [LW-1:0]           r_len [C_NUM_SEQ];
    logic                    r_cfg_err;

    logic [SW-1:0]           r_sel;
    logic [LW-1:0]           r_cur_len;
    logic [IW-1:0]           r_idx;
    logic [C_ADDR_WIDTH-1:0] r_addr;
    logic                    r_valid;
    logic                    r_last;

    logic                    w_start_acc;
    logic [LW-1:0]           w_start_len;
    logic                    w_accept;
    logic                    w_idx_ok;
    logic                    w_cfg_hit;
    logic [LW-1:0]           w_len_clamped;
    logic                    w_final_pass;
    logic                    w_start_final;

    assign w_start_acc   = s_if.start && (r_state == S_IDLE);
    assign w_start_len   = r_len[s_if.seq_sel];
    assign w_accept      = r_valid && s_if.wht_ready;
    assign w_len_clamped = (s_if.cfg_len > LW'(C_SEQ_DEPTH)) ? LW'(C_SEQ_DEPTH) : s_if.cfg_len;

    // A sequence may not change under the stream reading it, including the one a same-cycle start picks.
    assign w_cfg_hit = (w_busy && (s_if.cfg_seq_id == r_sel)) ||
                       (w_start_acc && (s_if.cfg_seq_id == s_if.seq_sel));

    // With a power-of-two depth every cfg_idx encoding is a real entry.
    generate
        if ((1 << IW) == C_SEQ_DEPTH) begin : g_idx_full
            assign w_idx_ok = 1'b1;
        end else begin : g_idx_chk
            assign w_idx_ok = (s_if.cfg_idx < IW'(C_SEQ_DEPTH));
        end
    endgenerate

`ifdef WHT_SEQ_REPEAT_EN
    logic [7:0] r_rpt_left;
    logic       w_end_pass;
    assign w_final_pass  = (r_rpt_left == 8'd0);
    assign w_start_final = (s_if.rpt_count == 8'd0);
    assign w_end_pass    = (LW'(r_idx) == (r_cur_len - LW'(1)));
`else
    assign w_final_pass  = 1'b1;
    assign w_start_final = 1'b1;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_if.start) w_state_nxt = (w_start_len == '0) ? S_FIN : S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_accept && r_last) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- table and config ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < C_NUM_SEQ; s++) begin
                r_len[s] <= '0;
                for (int e = 0; e < C_SEQ_DEPTH; e++) r_tab[s][e] <= '0;
            end
            r_cfg_err <= 1'b0;
        end else begin
            if (s_if.cfg_wr_en && w_idx_ok && !w_cfg_hit)
                r_tab[s_if.cfg_seq_id][s_if.cfg_idx] <= s_if.cfg_data;
            if (s_if.cfg_len_wr && !w_cfg_hit)
                r_len[s_if.cfg_seq_id] <= w_len_clamped;
            r_cfg_err <= (s_if.cfg_wr_en && (w_cfg_hit || !w_idx_ok)) ||
                         (s_if.cfg_len_wr && w_cfg_hit);
        end
    end

    // ---------------- stream output register ----------------
    // r_last is precomputed for the beat being loaded so it is registered alongside the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel     <= '0;
            r_cur_len <= '0;
            r_idx     <= '0;
            r_addr    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
`ifdef WHT_SEQ_REPEAT_EN
            r_rpt_left <= 8'd0;
`endif
        end else if (w_start_acc) begin
            r_sel     <= s_if.seq_sel;
            r_cur_len <= w_start_len;
            r_idx     <= '0;
            r_addr    <= r_tab[s_if.seq_sel][0];
            r_valid   <= (w_start_len != '0);
            r_last    <= (w_start_len == LW'(1)) && w_start_final;
`ifdef WHT_SEQ_REPEAT_EN
            r_rpt_left <= s_if.rpt_count;
`endif
        end else if (w_accept) begin
            if (r_last) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
`ifdef WHT_SEQ_REPEAT_EN
            else if (w_end_pass) begin
                // Wrap to entry 0 for the next pass with no bubble.
                r_idx      <= '0;
                r_addr     <= r_tab[r_sel][0];
                r_last     <= (r_cur_len == LW'(1)) && (r_rpt_left == 8'd1);
                r_rpt_left <= r_rpt_left - 8'd1;
            end
`endif
            else begin
                r_idx  <= r_idx + IW'(1);
                r_addr <= r_tab[r_sel][r_idx + IW'(1)];
                r_last <= ((LW'(r_idx) + LW'(2)) == r_cur_len) && w_final_pass;
            end
        end
    end

    assign s_if.cfg_err       = r_cfg_err;
    assign s_if.busy          = w_busy;
    assign s_if.done          = w_done;
    assign s_if.wht_valid     = r_valid;
    assign s_if.wht_data_addr = r_addr;
    assign s_if.wht_last      = r_last;
endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_gen.sv
// Purpose : self-checking bench for cnn_layer_accel_weight_seq_gen; expected beats queued at start,
//           checked by a negedge monitor on every accepted beat, plus done timing and status checks.
// Option  : define WHT_SEQ_REPEAT_EN to also exercise the repeat path.
module tb_cnn_layer_accel_weight_seq_gen;
    localparam int NS = 4;
    localparam int SD = 8;
    localparam int AW = 4;
    localparam int SW = $clog2(NS);
    localparam int IW = $clog2(SD);
    localparam int LW = $clog2(SD + 1);

    typedef struct {
        int addr;
        int last;
        int cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_layer_accel_weight_seq_gen_if #(.C_NUM_SEQ(NS), .C_SEQ_DEPTH(SD), .C_ADDR_WIDTH(AW)) u_if ();

    cnn_layer_accel_weight_seq_gen #(.C_NUM_SEQ(NS), .C_SEQ_DEPTH(SD), .C_ADDR_WIDTH(AW)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .s_if (u_if)
    );

    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    n_done = 0;
    int    exp_done_cyc = -1;
    beat_t sb_q[$];
    beat_t b;
    logic  prev_stall = 1'b0;
    int    prev_addr = 0;
    int    prev_last = 0;
    int    pat[$];
    int    none[$];

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_vld", int'(u_if.wht_valid), 1);
                chk("hold_addr", int'(u_if.wht_data_addr), prev_addr);
                chk("hold_last", int'(u_if.wht_last), prev_last);
            end
            if (u_if.wht_valid && u_if.wht_ready) begin
                chk("sb_nonempty", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    b = sb_q.pop_front();
                    chk("addr", int'(u_if.wht_data_addr), b.addr);
                    chk("last", int'(u_if.wht_last), b.last);
                    if (b.cyc >= 0) chk("beat_cyc", cyc, b.cyc);
                end
                if (u_if.wht_last) exp_done_cyc = cyc + 1;
            end
            if (u_if.done) begin
                n_done++;
                chk("done_cyc", cyc, exp_done_cyc);
                exp_done_cyc = -1;
            end
            prev_stall = u_if.wht_valid && !u_if.wht_ready;
            prev_addr  = int'(u_if.wht_data_addr);
            prev_last  = int'(u_if.wht_last);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_entry(input int s, input int i, input int d);
        u_if.cfg_wr_en  = 1'b1;
        u_if.cfg_seq_id = SW'(s);
        u_if.cfg_idx    = IW'(i);
        u_if.cfg_data   = AW'(d);
        tick();
        u_if.cfg_wr_en  = 1'b0;
    endtask

    task automatic cfg_length(input int s, input int l);
        u_if.cfg_len_wr = 1'b1;
        u_if.cfg_seq_id = SW'(s);
        u_if.cfg_len    = LW'(l);
        tick();
        u_if.cfg_len_wr = 1'b0;
    endtask

    task automatic load_seq(input int s, input int vals[$], input int l);
        foreach (vals[i]) cfg_entry(s, i, vals[i]);
        cfg_length(s, l);
    endtask

    // Queue the expected beats, then pulse start for one cycle.
    task automatic start_seq(input int s, input int vals[$], input int reps, input bit timed);
        int t;
        int n;
        t = cyc;
        n = vals.size();
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++)
                sb_q.push_back('{vals[i], int'(r == reps - 1 && i == n - 1),
                                 timed ? t + 1 + r * n + i : -1});
        if (n == 0) exp_done_cyc = t + 1;
        u_if.start   = 1'b1;
        u_if.seq_sel = SW'(s);
`ifdef WHT_SEQ_REPEAT_EN
        u_if.rpt_count = 8'(reps - 1);
`endif
        tick();
        u_if.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((u_if.busy || sb_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_finish"}, int'(n < 200), 1);
        tick();
    endtask

    initial begin
        rst             = 1'b1;
        u_if.cfg_wr_en  = 1'b0;
        u_if.cfg_len_wr = 1'b0;
        u_if.cfg_seq_id = '0;
        u_if.cfg_idx    = '0;
        u_if.cfg_data   = '0;
        u_if.cfg_len    = '0;
        u_if.start      = 1'b0;
        u_if.seq_sel    = '0;
        u_if.wht_ready  = 1'b1;
`ifdef WHT_SEQ_REPEAT_EN
        u_if.rpt_count  = 8'd0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", int'(u_if.busy), 0);
        chk("rst_valid", int'(u_if.wht_valid), 0);
        chk("rst_last", int'(u_if.wht_last), 0);
        chk("rst_done", int'(u_if.done), 0);
        chk("rst_err", int'(u_if.cfg_err), 0);
        chk("rst_addr", int'(u_if.wht_data_addr), 0);

        // Full-throughput stream of seq0
        pat = '{1, 9, 3, 4, 5};
        load_seq(0, pat, 5);
        start_seq(0, pat, 1, 1'b1);
        chk("run_busy", int'(u_if.busy), 1);
        wait_idle("t1");
        chk("t1_done_cnt", n_done, 1);

        // Same stream with backpressure on stream cycles 2-4
        start_seq(0, pat, 1, 1'b0);
        tick();
        u_if.wht_ready = 1'b0;
        repeat (3) tick();
        u_if.wht_ready = 1'b1;
        wait_idle("t2");
        chk("t2_done_cnt", n_done, 2);

        // Zero-length sequence: done and busy for exactly one cycle, no beats
        cfg_length(2, 0);
        start_seq(2, none, 1, 1'b1);
        chk("len0_busy", int'(u_if.busy), 1);
        chk("len0_valid", int'(u_if.wht_valid), 0);
        tick();
        chk("len0_busy_off", int'(u_if.busy), 0);
        chk("t3_done_cnt", n_done, 3);

        // Config writes during a stream: own sequence rejected, other accepted
        pat = '{2, 4, 6, 8};
        load_seq(1, pat, 4);
        pat = '{11, 12};
        load_seq(3, pat, 2);
        u_if.wht_ready = 1'b0;
        pat = '{2, 4, 6, 8};
        start_seq(1, pat, 1, 1'b0);
        cfg_entry(1, 0, 15);
        chk("busy_wr_err", int'(u_if.cfg_err), 1);
        cfg_entry(3, 0, 7);
        chk("other_wr_err", int'(u_if.cfg_err), 0);
        cfg_length(1, 2);
        chk("busy_len_err", int'(u_if.cfg_err), 1);
        u_if.wht_ready = 1'b1;
        wait_idle("t4");
        pat = '{7, 12};
        start_seq(3, pat, 1, 1'b1);
        wait_idle("t4b");
        // Write to the sequence picked by a same-cycle start
        u_if.cfg_wr_en  = 1'b1;
        u_if.cfg_seq_id = SW'(1);
        u_if.cfg_idx    = IW'(1);
        u_if.cfg_data   = AW'(13);
        pat = '{2, 4, 6, 8};
        start_seq(1, pat, 1, 1'b1);
        u_if.cfg_wr_en = 1'b0;
        chk("start_wr_err", int'(u_if.cfg_err), 1);
        wait_idle("t4c");
        chk("t4_done_cnt", n_done, 6);

        // Length clamp: 12 requested, depth 8
        pat = '{1, 9, 3, 4, 5, 10, 14, 2};
        load_seq(0, pat, 12);
        start_seq(0, pat, 1, 1'b1);
        wait_idle("t5");
        chk("t5_done_cnt", n_done, 7);

        // Reset mid-stream at beat 3
        start_seq(0, pat, 1, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", int'(u_if.wht_valid), 0);
        chk("mid_rst_busy", int'(u_if.busy), 0);
        chk("mid_rst_done", int'(u_if.done), 0);
        sb_q.delete();
        exp_done_cyc = -1;
        rst = 1'b0;
        tick();
        pat = '{0, 0, 0, 0, 0, 0, 0, 0};
        cfg_length(0, 8);
        start_seq(0, pat, 1, 1'b1);
        wait_idle("t6");
        start_seq(1, none, 1, 1'b1);
        wait_idle("t6b");
        chk("t6_done_cnt", n_done, 9);

`ifdef WHT_SEQ_REPEAT_EN
        // Three back-to-back passes, last only on the final beat
        pat = '{6, 7, 8};
        load_seq(2, pat, 3);
        start_seq(2, pat, 3, 1'b1);
        wait_idle("t7");
        chk("t7_done_cnt", n_done, 10);
`endif

        chk("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
